// File: rtl/rice_run_decoder.sv
`timescale 1ns/1ps
// rice_run_decoder
// Streaming Rice-code decoder. Packed MSB-first words are appended to a
// 2*IN_W bit window. A leading-run scan of the top SLICE_W bits measures the
// unary quotient. The next K bits are then taken as the remainder, and one
// value (q << K) | r is presented per code word with a valid/ready handshake.
module rice_run_decoder #(
    parameter int IN_W    = 32,
    parameter int SLICE_W = 4,
    parameter int K       = 4,
    parameter int Q_MAX   = 255,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             leading_bit,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_overflow,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int BUF_W  = 2 * IN_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int Q_W    = $clog2(Q_MAX + 1);
    localparam int C_W    = $clog2(SLICE_W + 1);
    localparam int SUM_W  = Q_W + C_W;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        REM  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BUF_W-1:0]    buf_q;
    logic [BUF_W-1:0]    buf_d;
    logic [BUF_W-1:0]    in_aligned;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic [FILL_W-1:0]   fill_rem;
    logic [FILL_W-1:0]   consume_n;
    logic [Q_W-1:0]      q_q;
    logic                sat_q;
    logic [Q_W:0]        q_add;
    logic [SLICE_W-1:0]  slice;
    logic                run_found;
    logic [C_W-1:0]      run_len;
    logic [K-1:0]        rem_bits;
    logic                accept;
    logic                scan_go;
    logic                rem_go;
    logic                emit_done;

    // Quotient accumulate with clamp at Q_MAX; MSB of the result flags that the
    // unclamped sum would have exceeded Q_MAX.
    function automatic logic [Q_W:0] q_sat_add(input logic [Q_W-1:0] a,
                                               input logic [C_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'(Q_MAX)) begin
            return {1'b1, Q_W'(Q_MAX)};
        end
        return {1'b0, sum[Q_W-1:0]};
    endfunction

    assign slice    = buf_q[BUF_W-1 -: SLICE_W];
    assign rem_bits = buf_q[BUF_W-1 -: K];
    assign q_add    = q_sat_add(q_q, run_len);

    // Leading-run encoder: position of the first bit that differs from leading_bit.
    always_comb begin
        run_found = 1'b0;
        run_len   = C_W'(SLICE_W);
        for (int i = 0; i < SLICE_W; i++) begin
            if (!run_found && (slice[SLICE_W-1-i] != leading_bit)) begin
                run_found = 1'b1;
                run_len   = C_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush always returns to SCAN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if ((fill_q >= FILL_W'(SLICE_W)) && run_found) state_d = REM;
            REM:     if (fill_q >= FILL_W'(K)) state_d = EMIT;
            EMIT:    if (out_ready) state_d = SCAN;
            default: state_d = SCAN;
        endcase
        if (flush) begin
            state_d = SCAN;
        end
    end

    // FSM outputs: handshakes and how many window bits are consumed this cycle.
    always_comb begin
        out_valid = (state_q == EMIT);
        in_ready  = (fill_q <= FILL_W'(IN_W)) && !flush;
        scan_go   = 1'b0;
        rem_go    = 1'b0;
        emit_done = 1'b0;
        consume_n = '0;
        case (state_q)
            SCAN: begin
                if (fill_q >= FILL_W'(SLICE_W)) begin
                    scan_go   = 1'b1;
                    consume_n = run_found ? (FILL_W'(run_len) + FILL_W'(1))
                                          : FILL_W'(SLICE_W);
                end
            end
            REM: begin
                if (fill_q >= FILL_W'(K)) begin
                    rem_go    = 1'b1;
                    consume_n = FILL_W'(K);
                end
            end
            EMIT:    emit_done = out_ready;
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Window update: drop consumed bits, then place an accepted word directly
    // below the remaining valid bits (bits below fill are always zero).
    always_comb begin
        fill_rem   = fill_q - consume_n;
        in_aligned = {in_data, {IN_W{1'b0}}} >> fill_rem;
        buf_d      = (buf_q << consume_n) | (accept ? in_aligned : '0);
        fill_d     = fill_rem + (accept ? FILL_W'(IN_W) : FILL_W'(0));
    end

    // Bit window and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else if (flush) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    // Quotient accumulator and sticky saturation flag for the current code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            sat_q <= 1'b0;
        end else if (flush || emit_done) begin
            q_q   <= '0;
            sat_q <= 1'b0;
        end else if (scan_go) begin
            q_q <= q_add[Q_W-1:0];
            if (q_add[Q_W]) begin
                sat_q <= 1'b1;
            end
        end
    end

    // Result register, loaded when the remainder is taken; held through EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_value    <= '0;
            out_overflow <= 1'b0;
        end else if (flush) begin
            out_overflow <= 1'b0;
        end else if (rem_go) begin
            out_value    <= (OUT_W'(q_q) << K) | OUT_W'(rem_bits);
            out_overflow <= sat_q;
        end
    end

endmodule

// File: tb/tb_rice_run_decoder.sv
`timescale 1ns/1ps
// Directed testbench for rice_run_decoder (IN_W=32, SLICE_W=4, K=4, Q_MAX=255).
module tb_rice_run_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        leading_bit = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_value;
    logic        out_overflow;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    rice_run_decoder #(
        .IN_W(32), .SLICE_W(4), .K(4), .Q_MAX(255), .OUT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .leading_bit(leading_bit),
        .flush(flush),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_value(out_value),
        .out_overflow(out_overflow),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle flush pulse with no input offered.
    task automatic do_flush();
        flush = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send_word(input logic [31:0] w);
        bit taken;
        taken = 1'b0;
        in_data = w;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (taken) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL send_word timeout: word %h never accepted", w);
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a negedge with out_valid high.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Accept the currently presented value.
    task automatic pulse_accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_value !== 16'h0000 || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b value=%h ovf=%b, want 0/0000/0",
                     out_valid, out_value, out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_flush();
        out_ready = 1'b0;
        leading_bit = 1'b0;
        in_data = 32'h1A00_0000;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_lat_e0: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_lat_e1: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 16'h003A || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_value: valid=%b value=%h ovf=%b, want 1/003A/0",
                     out_valid, out_value, out_overflow);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 16'h003A) begin
            failures++;
            $display("FAIL single_hold: valid=%b value=%h, want 1/003A", out_valid, out_value);
        end
        pulse_accept();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_release: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_span();
        bit seen;
        bit ok;
        leading_bit = 1'b1;
        do_flush();
        send_word(32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL span_early_valid: out_valid seen=%b want 0", seen);
        end
        send_word(32'h7000_0000);
        wait_valid(ok);
        checks++;
        if (!ok || out_value !== 16'h020E || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL span_value: ok=%b value=%h ovf=%b, want 1/020E/0",
                     ok, out_value, out_overflow);
        end
        if (ok) pulse_accept();
        leading_bit = 1'b0;
        do_flush();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_vals [12] = '{16'h003A, 16'h003B, 16'h003C, 16'h003D,
                                       16'h003E, 16'h003F, 16'h0030, 16'h0031,
                                       16'h0032, 16'h0033, 16'h0034, 16'h0035};
        do_flush();
        out_ready = 1'b0;
        fork
            begin
                send_word(32'h1A1B_1C1D);
                send_word(32'h1E1F_1011);
                send_word(32'h1213_1415);
            end
            begin
                bit ok;
                bit stable;
                logic [15:0] v0;
                wait_valid(ok);
                v0 = out_value;
                checks++;
                if (!ok || v0 !== exp_vals[0]) begin
                    failures++;
                    $display("FAIL bp_first: ok=%b value=%h want %h", ok, v0, exp_vals[0]);
                end
                stable = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_value !== v0) stable = 1'b0;
                end
                checks++;
                if (stable !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stable: value=%h valid=%b want %h held",
                             out_value, out_valid, v0);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready: got %b want 0 while window is full", in_ready);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                for (int i = 1; i < 12; i++) begin
                    wait_valid(ok);
                    checks++;
                    if (!ok || out_value !== exp_vals[i] || out_overflow !== 1'b0) begin
                        failures++;
                        $display("FAIL bp_code%0d: ok=%b value=%h ovf=%b want %h/0",
                                 i, ok, out_value, out_overflow, exp_vals[i]);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        do_flush();
    endtask

    task automatic test_saturation();
        do_flush();
        out_ready = 1'b0;
        leading_bit = 1'b0;
        fork
            begin
                for (int i = 0; i < 9; i++) send_word(32'h0000_0000);
                send_word(32'h9000_0000);
                send_word(32'h3A00_0000);
            end
            begin
                bit ok;
                wait_valid(ok);
                checks++;
                if (!ok || out_value !== 16'h0FF2 || out_overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL sat_value: ok=%b value=%h ovf=%b want 0FF2/1",
                             ok, out_value, out_overflow);
                end
                if (ok) pulse_accept();
                wait_valid(ok);
                checks++;
                if (!ok || out_value !== 16'h01DD || out_overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL sat_next: ok=%b value=%h ovf=%b want 01DD/0",
                             ok, out_value, out_overflow);
                end
                if (ok) pulse_accept();
            end
        join
        do_flush();
    endtask

    task automatic test_flush();
        bit ok;
        do_flush();
        out_ready = 1'b0;
        leading_bit = 1'b0;
        send_word(32'h1A00_0000);
        wait_valid(ok);
        do_flush();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL flush_emit: valid=%b ovf=%b want 0/0", out_valid, out_overflow);
        end
        send_word(32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        in_data = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        send_word(32'h1A00_0000);
        wait_valid(ok);
        checks++;
        if (!ok || out_value !== 16'h003A || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL flush_value: ok=%b value=%h ovf=%b want 003A/0",
                     ok, out_value, out_overflow);
        end
        if (ok) pulse_accept();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_flush();
        out_ready = 1'b0;
        send_word(32'h1A00_0000);
        wait_valid(ok);
        checks++;
        if (!ok || out_value !== 16'h003A) begin
            failures++;
            $display("FAIL rstmid_pre: ok=%b value=%h want 003A", ok, out_value);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_value !== 16'h0000 || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: valid=%b value=%h ovf=%b want 0/0000/0",
                     out_valid, out_value, out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_span();
        test_backpressure();
        test_saturation();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
